// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch port, load/store port, shared memory port.
// The master modport is the arbiter's view; slave is the surrounding core/memory.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            ibus_read;
  logic [AW-1:0]   ibus_address;
  logic            ibus_waitrequest;
  logic            ibus_readdatavalid;
  logic [DW-1:0]   ibus_readdata;

  logic            dbus_read;
  logic            dbus_write;
  logic [AW-1:0]   dbus_address;
  logic [DW-1:0]   dbus_writedata;
  logic [DW/8-1:0] dbus_byteenable;
  logic            dbus_waitrequest;
  logic            dbus_readdatavalid;
  logic [DW-1:0]   dbus_readdata;

  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_writedata;
  logic [DW/8-1:0] mem_byteenable;
  logic            mem_waitrequest;
  logic            mem_readdatavalid;
  logic [DW-1:0]   mem_readdata;

  logic            err_unexpected_rdv;

  modport master (
    input  ibus_read, ibus_address,
    output ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
    input  dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byteenable,
    output dbus_waitrequest, dbus_readdatavalid, dbus_readdata,
    output mem_read, mem_write, mem_address, mem_writedata, mem_byteenable,
    input  mem_waitrequest, mem_readdatavalid, mem_readdata,
    output err_unexpected_rdv
  );

  modport slave (
    output ibus_read, ibus_address,
    input  ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
    output dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byteenable,
    input  dbus_waitrequest, dbus_readdatavalid, dbus_readdata,
    input  mem_read, mem_write, mem_address, mem_writedata, mem_byteenable,
    output mem_waitrequest, mem_readdatavalid, mem_readdata,
    input  err_unexpected_rdv
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM memory port between ibus (fetch) and dbus (load/store), routing
// in-order read returns by a requester-ID FIFO. Define ARB_ROUND_ROBIN_EN for alternating grant.
//
// state     | meaning
// ST_OPEN   | no stalled command; grant decided by arbitration this cycle
// ST_LOCKED | owner's command was stalled; grant held on owner until accepted
module mem_bus_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.master bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t                     r_state, w_state_next;
  logic                       r_owner, w_owner_next;
  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
  logic [MAX_OUTSTANDING-1:0] r_id;
  logic                       r_err;
`ifdef ARB_ROUND_ROBIN_EN
  logic                       r_last_grant;
`endif

  logic            w_full, w_empty, w_i_req, w_d_req, w_i_elig, w_d_elig;
  logic            w_gnt_valid, w_gnt_id, w_mem_read, w_mem_write;
  logic            w_accept, w_push, w_pop, w_head;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [DW/8-1:0] w_be;

  // Full is judged on the registered count, so a same-cycle pop cannot admit a new read.
  assign w_full   = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty  = (r_count == '0);
  assign w_i_req  = bus.ibus_read;
  assign w_d_req  = bus.dbus_read | bus.dbus_write;
  assign w_i_elig = bus.ibus_read & ~w_full;
  assign w_d_elig = bus.dbus_write | (bus.dbus_read & ~w_full);

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (r_state == ST_LOCKED && (r_owner ? w_d_req : w_i_req)) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = r_owner;
    end else if (w_i_elig && w_d_elig) begin
      w_gnt_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      w_gnt_id    = ~r_last_grant;
`else
      w_gnt_id    = 1'b1;
`endif
    end else if (w_d_elig) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = 1'b1;
    end else if (w_i_elig) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = 1'b0;
    end
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_be        = '0;
    if (w_gnt_valid) begin
      if (w_gnt_id) begin
        w_mem_read  = bus.dbus_read & ~w_full;
        w_mem_write = bus.dbus_write;
        w_addr      = bus.dbus_address;
        w_wdata     = bus.dbus_writedata;
        w_be        = bus.dbus_byteenable;
      end else begin
        w_mem_read  = 1'b1;
        w_addr      = bus.ibus_address;
        w_be        = '1;
      end
    end
  end

  always_comb begin
    w_state_next = ST_OPEN;
    w_owner_next = r_owner;
    if (w_gnt_valid && (w_mem_read || w_mem_write) && bus.mem_waitrequest) begin
      w_state_next = ST_LOCKED;
      w_owner_next = w_gnt_id;
    end
  end

  assign w_accept = (w_mem_read | w_mem_write) & ~bus.mem_waitrequest;
  assign w_push   = w_accept & w_mem_read;
  assign w_pop    = bus.mem_readdatavalid & ~w_empty;
  assign w_head   = r_id[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_OPEN;
      r_owner  <= 1'b0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_id     <= '0;
      r_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      if (w_push) begin
        r_id[r_wr_ptr] <= w_gnt_id;
        r_wr_ptr       <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (bus.mem_readdatavalid && w_empty) r_err <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      if (w_accept) r_last_grant <= w_gnt_id;
`endif
    end
  end

  assign bus.mem_read           = w_mem_read;
  assign bus.mem_write          = w_mem_write;
  assign bus.mem_address        = w_addr;
  assign bus.mem_writedata      = w_wdata;
  assign bus.mem_byteenable     = w_be;
  assign bus.ibus_waitrequest   = ~(w_gnt_valid & ~w_gnt_id) | bus.mem_waitrequest;
  assign bus.dbus_waitrequest   = ~(w_gnt_valid & w_gnt_id) | bus.mem_waitrequest;
  assign bus.ibus_readdatavalid = w_pop & ~w_head;
  assign bus.dbus_readdatavalid = w_pop & w_head;
  assign bus.ibus_readdata      = bus.mem_readdata;
  assign bus.dbus_readdata      = bus.mem_readdata;
  assign bus.err_unexpected_rdv = r_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset-time vector table, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_mem_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: requester IDs of accepted reads, oldest first
  int       q[$];
  bit       m_lock, m_owner, m_last, m_err;
  bit       m_gv, m_g, m_mr, m_mw;
  bit       c_mwait, c_rdv;
  logic [31:0] g_wd = 32'hCAFE_0000;
  logic [3:0]  g_be = 4'h3;

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input bit mwait, input bit rdv,
                       input logic [31:0] rdata);
    bus.ibus_read         = ir;
    bus.ibus_address      = ia;
    bus.dbus_read         = dr;
    bus.dbus_write        = dw;
    bus.dbus_address      = da;
    bus.dbus_writedata    = g_wd;
    bus.dbus_byteenable   = g_be;
    bus.mem_waitrequest   = mwait;
    bus.mem_readdatavalid = rdv;
    bus.mem_readdata      = rdata;
  endtask

  task automatic model_reset();
    q.delete();
    m_lock = 0; m_owner = 0; m_last = 1; m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // drive one cycle's inputs at negedge, compare against the model before the next posedge
  task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                     input logic [31:0] da, input bit mwait, input bit rdv,
                     input logic [31:0] rdata);
    bit full, i_ok, d_ok, e_iw, e_dw, e_irdv, e_drdv;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    @(negedge clk);
    drive(ir, ia, dr, dw, da, mwait, rdv, rdata);
    c_mwait = mwait;
    c_rdv   = rdv;
    #1;
    full = (q.size() == MAXO);
    i_ok = ir && !full;
    d_ok = dw || (dr && !full);
    m_gv = 0; m_g = 0;
    if (m_lock && (m_owner ? (dr || dw) : ir)) begin m_gv = 1; m_g = m_owner; end
    else if (i_ok && d_ok) begin m_gv = 1; m_g = RR ? !m_last : 1'b1; end
    else if (d_ok) begin m_gv = 1; m_g = 1; end
    else if (i_ok) begin m_gv = 1; m_g = 0; end
    m_mr   = m_gv && (m_g ? (dr && !full) : 1'b1);
    m_mw   = m_gv && m_g && dw;
    e_addr = !m_gv ? 32'h0 : (m_g ? da : ia);
    e_wd   = (m_gv && m_g) ? g_wd : 32'h0;
    e_be   = !m_gv ? 4'h0 : (m_g ? g_be : 4'hF);
    e_iw   = !(m_gv && !m_g) || mwait;
    e_dw   = !(m_gv && m_g) || mwait;
    e_irdv = rdv && q.size() > 0 && q[0] == 0;
    e_drdv = rdv && q.size() > 0 && q[0] == 1;
    chk("ctl", {bus.mem_read, bus.mem_write, bus.ibus_waitrequest, bus.dbus_waitrequest,
                bus.ibus_readdatavalid, bus.dbus_readdatavalid, bus.err_unexpected_rdv},
               {m_mr, m_mw, e_iw, e_dw, e_irdv, e_drdv, m_err});
    chk("mux", {bus.mem_address, bus.mem_writedata, bus.mem_byteenable}, {e_addr, e_wd, e_be});
    chk("rdata", {bus.ibus_readdata, bus.dbus_readdata}, {rdata, rdata});
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = (m_mr || m_mw) && !c_mwait;
    if (c_rdv && q.size() == 0) m_err = 1;
    if (c_rdv && q.size() > 0) void'(q.pop_front());
    if (acc && m_mr) q.push_back(int'(m_g));
    m_lock  = m_gv && (m_mr || m_mw) && c_mwait;
    m_owner = m_g;
    if (acc) m_last = m_g;
  endtask

  typedef struct {
    bit ir; logic [31:0] ia; bit dr; bit dw; logic [31:0] da; bit mwait; bit rdv;
    bit e_mr; bit e_mw; bit e_iw; bit e_dw; logic [31:0] e_addr; logic [31:0] e_wd; logic [3:0] e_be;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a0, a1, a2;
    tbl[0] = '{0, 0,     0, 0, 0,     0, 0,  0, 0, 1, 1, 32'h0,   32'h0, 4'h0};
    tbl[1] = '{0, 0,     1, 0, 'h100, 0, 0,  1, 0, 1, 0, 32'h100, 32'hCAFE_0000, 4'h3};
    tbl[2] = RR ? '{1, 0, 0, 1, 'h200, 0, 0,  1, 0, 0, 1, 32'h0,   32'h0, 4'hF}
                : '{1, 0, 0, 1, 'h200, 0, 0,  0, 1, 1, 0, 32'h200, 32'hCAFE_0000, 4'h3};
    tbl[3] = '{1, 'h40,  0, 0, 0,     1, 0,  1, 0, 1, 1, 32'h40,  32'h0, 4'hF};
    tbl[4] = '{0, 0,     0, 1, 'h300, 1, 0,  0, 1, 1, 1, 32'h300, 32'hCAFE_0000, 4'h3};
    tbl[5] = RR ? '{1, 'h44, 1, 0, 'h104, 0, 0,  1, 0, 0, 1, 32'h44,  32'h0, 4'hF}
                : '{1, 'h44, 1, 0, 'h104, 0, 0,  1, 0, 1, 0, 32'h104, 32'hCAFE_0000, 4'h3};
    tbl[6] = '{0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 1, 32'h0,   32'h0, 4'h0};

    // vectors held in reset: tracking state stays at its reset value, grant is combinational
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].mwait, tbl[i].rdv, 32'h0);
      #1;
      chk($sformatf("tbl%0d_ctl", i),
          {bus.mem_read, bus.mem_write, bus.ibus_waitrequest, bus.dbus_waitrequest,
           bus.ibus_readdatavalid, bus.dbus_readdatavalid, bus.err_unexpected_rdv},
          {tbl[i].e_mr, tbl[i].e_mw, tbl[i].e_iw, tbl[i].e_dw, 3'b000});
      chk($sformatf("tbl%0d_mux", i), {bus.mem_address, bus.mem_writedata, bus.mem_byteenable},
          {tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_be});
    end

    // dbus read issues same cycle, data two cycles later goes to dbus only
    do_reset();
    cyc(0, 0, 1, 0, 'h100, 0, 0, 0);
    chk("first_read", {bus.mem_read, bus.mem_address}, {1'b1, 32'h100});
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0); tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 'h55);
    chk("first_rdv", {bus.dbus_readdatavalid, bus.ibus_readdatavalid}, 2'b10);
    tick();

    // contention: ibus read + dbus write
    do_reset();
    cyc(1, 0, 0, 1, 'h200, 0, 0, 0);
    chk("contend_addr", {bus.mem_address, bus.ibus_waitrequest}, RR ? {32'h0, 1'b0} : {32'h200, 1'b1});
    tick();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("contend_next", {bus.mem_read, bus.mem_address}, {1'b1, 32'h0});
    tick();

    // ibus stalled 3 cycles holds grant while dbus waits
    do_reset();
    cyc(1, 0, 0, 0, 0, 1, 0, 0); tick();
    cyc(1, 0, 1, 0, 'h100, 1, 0, 0);
    chk("lock_c2", bus.mem_address, 32'h0); tick();
    cyc(1, 0, 1, 0, 'h100, 1, 0, 0);
    chk("lock_c3", bus.mem_address, 32'h0); tick();
    cyc(1, 0, 1, 0, 'h100, 0, 0, 0);
    chk("lock_acc", {bus.mem_address, bus.ibus_waitrequest}, {32'h0, 1'b0}); tick();
    cyc(0, 0, 1, 0, 'h100, 0, 0, 0);
    chk("lock_after", {bus.mem_read, bus.mem_address}, {1'b1, 32'h100}); tick();

    // FIFO full: reads blocked, writes pass, a pop frees a slot only on the next cycle
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      cyc(1, 32'(i * 4), 0, 0, 0, 0, 0, 0); tick();
    end
    cyc(1, 'h10, 0, 1, 'h300, 0, 0, 0);
    chk("full_wr", {bus.ibus_waitrequest, bus.mem_read, bus.mem_write, bus.mem_address},
        {1'b1, 1'b0, 1'b1, 32'h300});
    tick();
    cyc(1, 'h10, 0, 0, 0, 0, 1, 'hAA);
    chk("full_pop", {bus.ibus_readdatavalid, bus.ibus_waitrequest, bus.mem_read}, 3'b110);
    tick();
    cyc(1, 'h10, 0, 0, 0, 0, 0, 0);
    chk("full_free", {bus.ibus_waitrequest, bus.mem_read, bus.mem_address}, {1'b0, 1'b1, 32'h10});
    tick();

    // in-order return routing
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0); tick();
    cyc(0, 0, 1, 0, 'h100, 0, 0, 0); tick();
    cyc(1, 'h8, 0, 0, 0, 0, 0, 0); tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 'hA);
    chk("route_a", {bus.ibus_readdatavalid, bus.dbus_readdatavalid, bus.ibus_readdata}, {2'b10, 32'hA});
    tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 'hB);
    chk("route_b", {bus.ibus_readdatavalid, bus.dbus_readdatavalid, bus.dbus_readdata}, {2'b01, 32'hB});
    tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 'hC);
    chk("route_c", {bus.ibus_readdatavalid, bus.dbus_readdatavalid, bus.ibus_readdata}, {2'b10, 32'hC});
    tick();

    // unexpected readdatavalid is sticky until reset, including responses to pre-reset reads
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1, 'h1);
    chk("unexp_rdv", {bus.ibus_readdatavalid, bus.dbus_readdatavalid}, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0); tick();
    end
    chk("err_sticky", bus.err_unexpected_rdv, 1'b1);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_cleared", bus.err_unexpected_rdv, 1'b0);
    tick();
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1, 'h2); tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_after_rst", bus.err_unexpected_rdv, 1'b1);
    tick();

    // continuous contention: alternation under round robin, dbus every time otherwise
    do_reset();
    cyc(1, 0, 1, 0, 'h100, 0, 0, 0); a0 = bus.mem_address; tick();
    cyc(1, 0, 1, 0, 'h100, 0, 0, 0); a1 = bus.mem_address; tick();
    cyc(1, 0, 1, 0, 'h100, 0, 0, 0); a2 = bus.mem_address; tick();
    chk("alt_grants", {a0, a1, a2}, RR ? {32'h0, 32'h100, 32'h0} : {32'h100, 32'h100, 32'h100});

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit ir, dr, dw, mw, rv;
      int op;
      if ($urandom_range(0, 299) == 0) do_reset();
      ir = ($urandom_range(0, 2) != 0);
      op = $urandom_range(0, 3);
      dr = (op == 1);
      dw = (op == 2);
      mw = ($urandom_range(0, 3) == 0);
      rv = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      g_wd = $urandom;
      g_be = 4'($urandom);
      cyc(ir, $urandom, dr, dw, $urandom, mw, rv, $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
